// File: rtl/usb_pkg.sv
// usb_pkg: shared constants and types for the USB full-speed transmit path.
//   - tx_packet_t : request codes driven by the endpoint controller
//   - tx_state_t  : transmitter FSM states
//   - PID / SYNC byte values, CRC16 parameters, line-state encodings
//   - pid_of()    : maps a request code to the PID byte placed on the wire
package usb_pkg;

  localparam int BIT_PERIOD_DEF = 8;

  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA0 = 3'd1,
    TX_ACK   = 3'd2,
    TX_NAK   = 3'd3,
    TX_STALL = 3'd4
  } tx_packet_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_EOP
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  // {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [7:0] pid_of(input logic [2:0] code);
    case (code)
      TX_DATA0: return PID_DATA0;
      TX_ACK:   return PID_ACK;
      TX_NAK:   return PID_NAK;
      TX_STALL: return PID_STALL;
      default:  return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_if.sv
// usb_tx_if: request / data-buffer / bus-line bundle of the USB transmitter.
//   master : endpoint controller + data buffer side (drives request, occupancy, head byte)
//   slave  : usb_tx (drives pop strobe, status and the d_plus/d_minus lines)
interface usb_tx_if;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data;
  logic       tx_transfer_active;
  logic       tx_error;
  logic       d_plus;
  logic       d_minus;

  modport master (
    output tx_packet, buffer_occupancy, tx_packet_data,
    input  get_tx_packet_data, tx_transfer_active, tx_error, d_plus, d_minus
  );

  modport slave (
    input  tx_packet, buffer_occupancy, tx_packet_data,
    output get_tx_packet_data, tx_transfer_active, tx_error, d_plus, d_minus
  );
endinterface

// File: rtl/usb_tx_crc16.sv
// usb_tx_crc16: bit-serial CRC16 (reflected 0x8005), LSB-first data.
//   clk, n_rst : clock, async active-low reset (register -> 0xFFFF)
//   i_clr      : reload the initial value
//   i_en       : fold i_bit into the register this cycle
//   o_crc      : complemented register, ready to transmit LSB first
module usb_tx_crc16 import usb_pkg::*; (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);
  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb  = r_crc[0] ^ i_bit;
  assign o_crc = ~r_crc;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     r_crc <= CRC16_INIT;
    else if (i_clr) r_crc <= CRC16_INIT;
    else if (i_en)  r_crc <= (r_crc >> 1) ^ (w_fb ? CRC16_POLY_REFL : 16'h0000);
  end
endmodule

// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter (handshakes and DATA0).
//   clk, n_rst : clock, async active-low reset (lines forced to idle J)
//   bus        : usb_tx_if.slave -- tx_packet request, buffer occupancy/head byte,
//                pop strobe, tx_transfer_active, tx_error, d_plus/d_minus
// Serialises SYNC, PID, payload, CRC16 and EOP with bit stuffing and NRZI,
// each wire bit held BIT_PERIOD clocks. All wire decisions are made on the
// last clock of the current bit, so the registered lines change on bit edges.
module usb_tx import usb_pkg::*; #(
  parameter int BIT_PERIOD  = BIT_PERIOD_DEF,
  parameter int MAX_PAYLOAD = 64
) (
  input  logic     clk,
  input  logic     n_rst,
  usb_tx_if.slave  bus
);
  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BW = $clog2(MAX_PAYLOAD + 1);

  tx_state_t   r_state, w_state;
  logic [TW-1:0] r_timer, w_timer;
  logic [15:0] r_shift, w_shift;
  logic [3:0]  r_bitcnt, w_bitcnt;
  logic [2:0]  r_ones, w_ones;
  logic [BW-1:0] r_bytes, w_bytes;
  logic [7:0]  r_pid, w_pid;
  logic        r_data0, w_data0;
  logic        r_nrzi, w_nrzi;       // 1 = J
  logic        r_active, w_active;
  logic        r_err, w_err;
  logic [1:0]  r_line, w_line;

  logic        w_bnd, w_emit, w_bit, w_stuff, w_get, w_eop_done;
  logic        w_crc_clr, w_crc_en, w_can_load, w_valid, w_rsvd;
  logic [3:0]  w_last;
  logic [15:0] w_crc;

  usb_tx_crc16 u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (w_bit),
    .o_crc (w_crc)
  );

  assign w_bnd      = (r_state != ST_IDLE) && (r_timer == TW'(BIT_PERIOD - 1));
  assign w_last     = (r_state == ST_CRC) ? 4'd15 : 4'd7;
  assign w_can_load = (bus.buffer_occupancy != 7'd0) && (r_bytes < BW'(MAX_PAYLOAD));
  assign w_valid    = (bus.tx_packet >= 3'd1) && (bus.tx_packet <= 3'd4);
  assign w_rsvd     = (bus.tx_packet >= 3'd5);

  always_comb begin
    w_state = r_state;  w_timer = r_timer + TW'(1);
    w_shift = r_shift;  w_bitcnt = r_bitcnt;  w_ones = r_ones;
    w_bytes = r_bytes;  w_pid = r_pid;  w_data0 = r_data0;
    w_nrzi = r_nrzi;  w_active = r_active;  w_err = r_err;  w_line = r_line;
    w_emit = 1'b0;  w_bit = 1'b0;  w_stuff = 1'b0;  w_get = 1'b0;
    w_crc_clr = 1'b0;  w_crc_en = 1'b0;  w_eop_done = 1'b0;

    if (r_state == ST_IDLE || w_bnd) w_timer = '0;

    if (w_bnd) begin
      unique case (r_state)
        ST_SYNC: begin
          w_emit = 1'b1;
          if (r_bitcnt == 4'd7) begin
            w_state = ST_PID;  w_shift = {8'h00, r_pid};  w_bitcnt = 4'd0;  w_bit = r_pid[0];
          end else begin
            w_shift = r_shift >> 1;  w_bitcnt = r_bitcnt + 4'd1;  w_bit = r_shift[1];
          end
        end
        ST_PID, ST_DATA, ST_CRC: begin
          if (r_ones == 3'd6) begin
            // stuff bit: shifter and CRC hold, field position unchanged
            w_stuff = 1'b1;  w_emit = 1'b1;  w_bit = 1'b0;  w_ones = 3'd0;
          end else if (r_bitcnt != w_last) begin
            w_emit = 1'b1;  w_shift = r_shift >> 1;  w_bitcnt = r_bitcnt + 4'd1;  w_bit = r_shift[1];
          end else if (r_state == ST_CRC || (r_state == ST_PID && !r_data0)) begin
            w_state = ST_EOP;  w_bitcnt = 4'd0;  w_line = LINE_SE0;
          end else if (w_can_load) begin
            // FWFT buffer: head byte is captured on the same edge that pops it
            w_state = ST_DATA;  w_shift = {8'h00, bus.tx_packet_data};  w_bitcnt = 4'd0;
            w_bytes = r_bytes + BW'(1);  w_get = 1'b1;  w_emit = 1'b1;  w_bit = bus.tx_packet_data[0];
          end else begin
            w_state = ST_CRC;  w_shift = w_crc;  w_bitcnt = 4'd0;  w_emit = 1'b1;  w_bit = w_crc[0];
          end
        end
        ST_EOP: begin
          if (r_bitcnt == 4'd0) begin
            w_bitcnt = 4'd1;
          end else if (r_bitcnt == 4'd1) begin
            w_bitcnt = 4'd2;  w_line = LINE_J;  w_nrzi = 1'b1;
          end else begin
            w_state = ST_IDLE;  w_active = 1'b0;  w_bitcnt = 4'd0;  w_eop_done = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (w_emit) begin
      w_nrzi = w_bit ? r_nrzi : ~r_nrzi;
      w_line = w_nrzi ? LINE_J : LINE_K;
      if (!w_stuff) begin
        // SYNC bits never count toward stuffing; only payload feeds the CRC
        if (w_state != ST_SYNC) w_ones = w_bit ? r_ones + 3'd1 : 3'd0;
        if (w_state == ST_DATA) w_crc_en = 1'b1;
      end
    end

    // Requests are taken in IDLE or on the edge that ends the EOP J bit.
    if (r_state == ST_IDLE || w_eop_done) begin
      if (w_valid) begin
        w_state = ST_SYNC;  w_active = 1'b1;  w_err = 1'b0;
        w_pid = pid_of(bus.tx_packet);  w_data0 = (bus.tx_packet == TX_DATA0);
        w_shift = {8'h00, SYNC_BYTE};  w_bitcnt = 4'd0;  w_ones = 3'd0;  w_bytes = '0;
        w_timer = '0;  w_crc_clr = 1'b1;
        // first SYNC bit is 0: toggle from idle J to K
        w_nrzi = 1'b0;  w_line = LINE_K;
      end else if (w_rsvd) begin
        w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;  r_timer <= '0;  r_shift <= '0;  r_bitcnt <= '0;
      r_ones <= '0;  r_bytes <= '0;  r_pid <= '0;  r_data0 <= 1'b0;
      r_nrzi <= 1'b1;  r_active <= 1'b0;  r_err <= 1'b0;  r_line <= LINE_J;
    end else begin
      r_state <= w_state;  r_timer <= w_timer;  r_shift <= w_shift;  r_bitcnt <= w_bitcnt;
      r_ones <= w_ones;  r_bytes <= w_bytes;  r_pid <= w_pid;  r_data0 <= w_data0;
      r_nrzi <= w_nrzi;  r_active <= w_active;  r_err <= w_err;  r_line <= w_line;
    end
  end

  assign bus.d_plus             = r_line[1];
  assign bus.d_minus            = r_line[0];
  assign bus.tx_transfer_active = r_active;
  assign bus.tx_error           = r_err;
  assign bus.get_tx_packet_data = w_get;
endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: scoreboard bench for usb_tx. Each request pushes the expected
// wire line states (one per bit period) computed from SYNC/PID/payload/CRC16
// with stuffing and NRZI; the monitor pops them and checks every clock.
module tb_usb_tx;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_tx_if bus();

  usb_tx #(.BIT_PERIOD(8), .MAX_PAYLOAD(64)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] fifo[$];
  logic [1:0] exp_q[$];
  int pops = 0;
  int bad_pops = 0;

  // first-word-fall-through data buffer model
  always @(posedge clk) begin : buf_model
    int n;
    if (bus.get_tx_packet_data === 1'b1) begin
      if (bus.buffer_occupancy == 7'd0) bad_pops++;
      if (fifo.size() > 0) void'(fifo.pop_front());
      pops++;
    end
    n = (fifo.size() > 127) ? 127 : fifo.size();
    bus.buffer_occupancy <= 7'(n);
    bus.tx_packet_data   <= (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  function automatic logic [15:0] crc16_tx(input logic [7:0] pay[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (pay[i]) begin
      logic [7:0] d = pay[i];
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ d[j]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_packet(input logic [2:0] code, input logic [7:0] pay[$]);
    bit bits[$];
    bit stf[$];
    logic [7:0] sync = 8'h80;
    logic [7:0] pid;
    logic [15:0] crc;
    logic lvl = 1'b1;
    int ones = 0;
    case (code)
      3'd1: pid = 8'hC3;
      3'd2: pid = 8'hD2;
      3'd3: pid = 8'h5A;
      default: pid = 8'h1E;
    endcase
    for (int i = 0; i < 8; i++) begin bits.push_back(sync[i]); stf.push_back(1'b0); end
    for (int i = 0; i < 8; i++) begin bits.push_back(pid[i]); stf.push_back(1'b1); end
    if (code == 3'd1) begin
      foreach (pay[k]) begin
        logic [7:0] d = pay[k];
        for (int i = 0; i < 8; i++) begin bits.push_back(d[i]); stf.push_back(1'b1); end
      end
      crc = crc16_tx(pay);
      for (int i = 0; i < 16; i++) begin bits.push_back(crc[i]); stf.push_back(1'b1); end
    end
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      exp_q.push_back(lvl ? 2'b10 : 2'b01);
      if (stf[i]) begin
        ones = bits[i] ? ones + 1 : 0;
        if (ones == 6) begin
          lvl = ~lvl;
          exp_q.push_back(lvl ? 2'b10 : 2'b01);
          ones = 0;
        end
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  // pre_acc: request already accepted on the previous packet's final edge.
  // inj_idx/inj_code: request driven mid-packet (must be ignored).
  // nxt_code: request driven on the last clock so it lands on the end edge.
  task automatic run_packet(input string name, input logic [2:0] code, input bit pre_acc,
                            input int inj_idx, input logic [2:0] inj_code,
                            input logic [2:0] nxt_code);
    logic [7:0] pay[$];
    int n_pay, idx, p0, bp0, misaligned;
    bit bad;
    logic [1:0] e;
    n_pay = 0;
    if (code == 3'd1) n_pay = (fifo.size() < 64) ? fifo.size() : 64;
    for (int i = 0; i < n_pay; i++) pay.push_back(fifo[i]);
    exp_q.delete();
    push_packet(code, pay);
    if (!pre_acc) begin
      @(negedge clk);
      bus.tx_packet = code;
      @(posedge clk);
    end
    p0 = pops; bp0 = bad_pops; bad = 1'b0; idx = 0; misaligned = 0;
    while (exp_q.size() > 0 && !bad) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (idx == 0) bus.tx_packet = 3'd0;
        if (idx == inj_idx) bus.tx_packet = inj_code;
        if (idx == inj_idx + 1) bus.tx_packet = 3'd0;
        tests++;
        if ({bus.d_plus, bus.d_minus} !== e || bus.tx_transfer_active !== 1'b1) begin
          fails++;
          $display("FAIL %s wire clk %0d: got line=%b active=%b, want line=%b active=1",
                   name, idx, {bus.d_plus, bus.d_minus}, bus.tx_transfer_active, e);
          bad = 1'b1;
          break;
        end
        if (bus.get_tx_packet_data === 1'b1 && (idx % 8) != 7) misaligned++;
        idx++;
        if (exp_q.size() == 0 && k == 7 && nxt_code != 3'd0) bus.tx_packet = nxt_code;
      end
    end
    if (bad) begin
      exp_q.delete();
      bus.tx_packet = 3'd0;
      for (int i = 0; i < 6000 && bus.tx_transfer_active === 1'b1; i++) @(negedge clk);
    end else if (nxt_code == 3'd0) begin
      @(negedge clk);
      tests++;
      if (bus.tx_transfer_active !== 1'b0 || {bus.d_plus, bus.d_minus} !== 2'b10) begin
        fails++;
        $display("FAIL %s end: got active=%b line=%b, want active=0 line=10",
                 name, bus.tx_transfer_active, {bus.d_plus, bus.d_minus});
      end
    end
    tests++;
    if (pops - p0 !== n_pay) begin
      fails++;
      $display("FAIL %s pop count: got %0d, want %0d", name, pops - p0, n_pay);
    end
    tests++;
    if (misaligned !== 0 || bad_pops !== bp0) begin
      fails++;
      $display("FAIL %s pop timing: got %0d off-boundary, %0d on empty, want 0/0",
               name, misaligned, bad_pops - bp0);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.tx_packet = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.d_plus, bus.d_minus, bus.tx_transfer_active, bus.get_tx_packet_data, bus.tx_error} !== 5'b10000) begin
      fails++;
      $display("FAIL reset outputs: got dp,dm,act,get,err=%b, want 10000",
               {bus.d_plus, bus.d_minus, bus.tx_transfer_active, bus.get_tx_packet_data, bus.tx_error});
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.d_plus, bus.d_minus, bus.tx_transfer_active} !== 3'b100) begin
      fails++;
      $display("FAIL idle after reset: got dp,dm,act=%b, want 100",
               {bus.d_plus, bus.d_minus, bus.tx_transfer_active});
    end
  endtask

  task automatic test_ack();
    run_packet("ack", 3'd2, 1'b0, -10, 3'd0, 3'd0);
  endtask

  task automatic test_data0_empty();
    fifo.delete();
    repeat (2) @(negedge clk);
    run_packet("data0_empty", 3'd1, 1'b0, -10, 3'd0, 3'd0);
  endtask

  task automatic test_data0_two();
    fifo.delete();
    fifo.push_back(8'hAA);
    fifo.push_back(8'hFF);
    repeat (2) @(negedge clk);
    run_packet("data0_aa_ff", 3'd1, 1'b0, -10, 3'd0, 3'd0);
  endtask

  task automatic test_data0_random();
    fifo.delete();
    for (int i = 0; i < 6; i++) fifo.push_back(8'($urandom_range(0, 255)));
    fifo.push_back(8'hFF);
    fifo.push_back(8'h7F);
    repeat (2) @(negedge clk);
    run_packet("data0_random", 3'd1, 1'b0, -10, 3'd0, 3'd0);
  endtask

  task automatic test_max_payload();
    fifo.delete();
    for (int i = 0; i < 70; i++) fifo.push_back(8'(i * 37 + 5));
    repeat (2) @(negedge clk);
    run_packet("max_payload", 3'd1, 1'b0, -10, 3'd0, 3'd0);
    tests++;
    if (bus.buffer_occupancy !== 7'd6) begin
      fails++;
      $display("FAIL max_payload leftover: got %0d, want 6", bus.buffer_occupancy);
    end
    fifo.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall_ignored();
    fifo.delete();
    fifo.push_back(8'h3C);
    fifo.push_back(8'h0F);
    fifo.push_back(8'h81);
    repeat (2) @(negedge clk);
    run_packet("stall_ignored", 3'd1, 1'b0, 150, 3'd4, 3'd0);
  endtask

  task automatic test_reserved();
    @(negedge clk);
    bus.tx_packet = 3'd6;
    @(negedge clk);
    bus.tx_packet = 3'd0;
    tests++;
    if (bus.tx_error !== 1'b1) begin
      fails++;
      $display("FAIL reserved tx_error: got %b, want 1", bus.tx_error);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.d_plus, bus.d_minus, bus.tx_transfer_active} !== 3'b100) begin
        fails++;
        $display("FAIL reserved idle clk %0d: got dp,dm,act=%b, want 100",
                 i, {bus.d_plus, bus.d_minus, bus.tx_transfer_active});
        break;
      end
    end
    run_packet("nak_after_err", 3'd3, 1'b0, -10, 3'd0, 3'd0);
    tests++;
    if (bus.tx_error !== 1'b0) begin
      fails++;
      $display("FAIL tx_error clear: got %b, want 0", bus.tx_error);
    end
  endtask

  task automatic test_reset_mid();
    fifo.delete();
    for (int i = 0; i < 4; i++) fifo.push_back(8'h11 * (i + 1));
    repeat (2) @(negedge clk);
    bus.tx_packet = 3'd1;
    @(negedge clk);
    bus.tx_packet = 3'd0;
    repeat (200) @(negedge clk);
    tests++;
    if (bus.tx_transfer_active !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid pre: got active=%b, want 1", bus.tx_transfer_active);
    end
    #2 n_rst = 1'b0;
    #1;
    tests++;
    if ({bus.d_plus, bus.d_minus, bus.tx_transfer_active, bus.get_tx_packet_data} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_mid immediate: got dp,dm,act,get=%b, want 1000",
               {bus.d_plus, bus.d_minus, bus.tx_transfer_active, bus.get_tx_packet_data});
    end
    @(negedge clk);
    fifo.delete();
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    run_packet("nak_after_reset", 3'd3, 1'b0, -10, 3'd0, 3'd0);
  endtask

  task automatic test_back_to_back();
    run_packet("b2b_ack", 3'd2, 1'b0, -10, 3'd0, 3'd3);
    run_packet("b2b_nak", 3'd3, 1'b1, -10, 3'd0, 3'd0);
  endtask

  initial begin
    bus.tx_packet = 3'd0;
    test_reset();
    test_ack();
    test_data0_empty();
    test_data0_two();
    test_data0_random();
    test_max_payload();
    test_stall_ignored();
    test_reserved();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
